i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_master.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master -- single-target I2C master for 16-bit register reads/writes.
//
// A transaction writes a 16-bit register address and then either writes
// 16 bits of data or does a repeated START and reads 16 bits back. Timing
// is derived from one 10-bit phase counter. Each bit slot is an SCL-low half
// followed by an SCL-high half. SDA is driven at the middle of the low half,
// and SDA is sampled at the middle of the high half.
//
// Optional feature macro: I2C_MASTER_STRETCH_EN adds the iSCL input. While
// SCL is released and the bus is held low, the phase counter freezes, so a
// target can stretch the clock.
//
// Parameters:
//   HALF_PERIOD  CLK cycles per SCL half-period (4..1023)
//   DEV_ID       7-bit target address
// Ports:
//   CLK, Reset   clock, synchronous active-high reset
//   Start        one-cycle request, accepted only while Busy=0
//   RnW          1=read, 0=write (sampled with Start)
//   RegAddr      16-bit register address (sampled with Start)
//   WrData       16-bit write data (sampled with Start)
//   iSDA         sampled SDA line level
//   iSCL         sampled SCL line level (I2C_MASTER_STRETCH_EN only)
//   oSDA         open-drain SDA drive (0=pull low, 1=release)
//   SCL          generated serial clock
//   RdData       read result, valid from Done until the next accepted Start
//   Busy         transaction in progress (includes the Done cycle)
//   Done         one-cycle end-of-transaction pulse
//   AckErr       target NACKed; held until the next accepted Start
module i2c_master #(
    parameter int         HALF_PERIOD = 125,
    parameter logic [6:0] DEV_ID      = 7'h05
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        RnW,
    input  logic [15:0] RegAddr,
    input  logic [15:0] WrData,
    input  logic        iSDA,
`ifdef I2C_MASTER_STRETCH_EN
    input  logic        iSCL,
`endif
    output logic        oSDA,
    output logic        SCL,
    output logic [15:0] RdData,
    output logic        Busy,
    output logic        Done,
    output logic        AckErr
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_ACK    = 4'd3;
    localparam logic [3:0] S_REG_HI = 4'd4;
    localparam logic [3:0] S_REG_LO = 4'd5;
    localparam logic [3:0] S_WR_HI  = 4'd6;
    localparam logic [3:0] S_WR_LO  = 4'd7;
    localparam logic [3:0] S_RSTART = 4'd8;
    localparam logic [3:0] S_ADDR_R = 4'd9;
    localparam logic [3:0] S_RD_HI  = 4'd10;
    localparam logic [3:0] S_MACK   = 4'd11;
    localparam logic [3:0] S_RD_LO  = 4'd12;
    localparam logic [3:0] S_MNACK  = 4'd13;
    localparam logic [3:0] S_STOP   = 4'd14;

    // The last count of a half-period, and the count whose following edge
    // lands exactly HALF_PERIOD/2 cycles into the half.
    localparam logic [9:0] HP_LAST = 10'(HALF_PERIOD - 1);
    localparam logic [9:0] MID     = 10'(HALF_PERIOD / 2 - 1);

    logic [3:0]  state_q, state_d;
    logic [3:0]  prev_q, prev_d;     // byte state that preceded the current ACK
    logic [9:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;         // transmit shift register, MSB goes out first
    logic [15:0] rx_q, rx_d;         // both read bytes, high byte shifted in first
    logic        rnw_q, rnw_d;
    logic [15:0] reg_q, reg_d;
    logic [15:0] wr_q, wr_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        nack_q, nack_d;
    logic        done_q, done_d;
    logic        ackerr_q, ackerr_d;
    logic [15:0] rdata_q, rdata_d;

    logic busy;
    logic stall;
    logic cnt_end;
    logic cnt_mid;
    logic slot_end;
    logic tx_bit;

    assign busy    = (state_q != S_IDLE) || done_q;
    assign cnt_end = (cnt_q == HP_LAST);
    assign cnt_mid = (cnt_q == MID);

`ifdef I2C_MASTER_STRETCH_EN
    // Stretching only matters while SCL is released by this master.
    assign stall = scl_q && !iSCL && (state_q != S_IDLE);
`else
    assign stall = 1'b0;
`endif

    // Level that the current bit slot puts on SDA during its low half.
    always_comb begin
        tx_bit = sh_q[7];
        case (state_q)
            S_ACK, S_RD_HI, S_RD_LO, S_MNACK: tx_bit = 1'b1;
            S_MACK:                           tx_bit = 1'b0;
            default:                          tx_bit = sh_q[7];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        rnw_d    = rnw_q;
        reg_d    = reg_q;
        wr_d     = wr_q;
        scl_d    = scl_q;
        sda_d    = sda_q;
        nack_d   = nack_q;
        done_d   = 1'b0;
        ackerr_d = ackerr_q;
        rdata_d  = rdata_q;
        slot_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                // During the Done cycle busy is still high, so a Start is dropped.
                if (Start && !busy) begin
                    rnw_d    = RnW;
                    reg_d    = RegAddr;
                    wr_d     = WrData;
                    ackerr_d = 1'b0;
                    sda_d    = 1'b0;          // START: SDA falls while SCL is high
                    cnt_d    = '0;
                    state_d  = S_START;
                end
            end

            S_START: begin
                if (!stall) begin
                    if (cnt_end) begin
                        cnt_d   = '0;
                        scl_d   = 1'b0;
                        sh_d    = {DEV_ID, 1'b0};
                        bit_d   = 3'd7;
                        state_d = S_ADDR;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end

            // Low half releases SDA. The first high half keeps SDA released,
            // and the second high half has SDA low. The level of sda_q tells
            // the two high halves apart.
            S_RSTART: begin
                if (!stall) begin
                    if (!cnt_end) begin
                        cnt_d = cnt_q + 10'd1;
                        if (!scl_q && cnt_mid) sda_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (!scl_q) begin
                            scl_d = 1'b1;
                        end else if (sda_q) begin
                            sda_d = 1'b0;
                        end else begin
                            scl_d   = 1'b0;
                            sh_d    = {DEV_ID, 1'b1};
                            bit_d   = 3'd7;
                            state_d = S_ADDR_R;
                        end
                    end
                end
            end

            S_STOP: begin
                if (!stall) begin
                    if (!cnt_end) begin
                        cnt_d = cnt_q + 10'd1;
                        if (!scl_q && cnt_mid) sda_d = 1'b0;
                    end else begin
                        cnt_d = '0;
                        if (!scl_q) begin
                            scl_d = 1'b1;
                        end else begin
                            sda_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            // All byte, ACK and master-ACK states share the same slot timing.
            default: begin
                if (!stall) begin
                    if (!scl_q && cnt_mid) sda_d = tx_bit;
                    if (scl_q && cnt_mid) begin
                        case (state_q)
                            S_ACK:            nack_d = iSDA;
                            S_RD_HI, S_RD_LO: rx_d   = {rx_q[14:0], iSDA};
                            default:          ;
                        endcase
                    end
                    if (!cnt_end) begin
                        cnt_d = cnt_q + 10'd1;
                    end else begin
                        cnt_d    = '0;
                        scl_d    = !scl_q;
                        slot_end = scl_q;
                    end
                end
            end
        endcase

        if (slot_end) begin
            case (state_q)
                S_ADDR, S_REG_HI, S_REG_LO, S_WR_HI, S_WR_LO, S_ADDR_R: begin
                    if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                    end else begin
                        prev_d  = state_q;
                        state_d = S_ACK;
                    end
                end
                S_RD_HI: begin
                    if (bit_q != 3'd0) bit_d = bit_q - 3'd1;
                    else               state_d = S_MACK;
                end
                S_RD_LO: begin
                    if (bit_q != 3'd0) bit_d = bit_q - 3'd1;
                    else               state_d = S_MNACK;
                end
                S_MACK: begin
                    bit_d   = 3'd7;
                    state_d = S_RD_LO;
                end
                S_MNACK: begin
                    rdata_d = rx_q;
                    state_d = S_STOP;
                end
                S_ACK: begin
                    if (nack_q) begin
                        ackerr_d = 1'b1;
                        state_d  = S_STOP;
                    end else begin
                        bit_d = 3'd7;
                        case (prev_q)
                            S_ADDR: begin
                                sh_d    = reg_q[15:8];
                                state_d = S_REG_HI;
                            end
                            S_REG_HI: begin
                                sh_d    = reg_q[7:0];
                                state_d = S_REG_LO;
                            end
                            S_REG_LO: begin
                                sh_d    = wr_q[15:8];
                                state_d = rnw_q ? S_RSTART : S_WR_HI;
                            end
                            S_WR_HI: begin
                                sh_d    = wr_q[7:0];
                                state_d = S_WR_LO;
                            end
                            S_ADDR_R: state_d = S_RD_HI;
                            default:  state_d = S_STOP;
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            prev_q   <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
            rnw_q    <= 1'b0;
            reg_q    <= '0;
            wr_q     <= '0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            ackerr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            rnw_q    <= rnw_d;
            reg_q    <= reg_d;
            wr_q     <= wr_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            nack_q   <= nack_d;
            done_q   <= done_d;
            ackerr_q <= ackerr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign SCL    = scl_q;
    assign oSDA   = sda_q;
    assign RdData = rdata_q;
    assign Busy   = busy;
    assign Done   = done_q;
    assign AckErr = ackerr_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural I2C target on the bus.
module tb_i2c_master;
    localparam int HP = 125;

    logic        CLK = 1'b0;
    logic        Reset, Start, RnW;
    logic [15:0] RegAddr, WrData, RdData;
    logic        iSDA, oSDA, SCL, Busy, Done, AckErr;
`ifdef I2C_MASTER_STRETCH_EN
    logic        iSCL = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    i2c_master #(.HALF_PERIOD(HP), .DEV_ID(7'h05)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .RnW(RnW),
        .RegAddr(RegAddr), .WrData(WrData), .iSDA(iSDA),
`ifdef I2C_MASTER_STRETCH_EN
        .iSCL(iSCL),
`endif
        .oSDA(oSDA), .SCL(SCL), .RdData(RdData), .Busy(Busy),
        .Done(Done), .AckErr(AckErr)
    );

    // Target model: wired-AND bus, bit counting on SCL edges.
    logic       slv = 1'b1;
    assign iSDA = oSDA & slv;

    logic       bus;
    logic       pscl = 1'b1, psda = 1'b1;
    int         bc = 0;
    logic [7:0] sr = '0, tx = '0;
    logic       rd_mode = 1'b0, next_rd = 1'b0, first_byte = 1'b0, mack_bit = 1'b0;
    logic       nack_addr = 1'b0;
    logic [7:0] got[$];
    logic [7:0] rdq[$];
    logic       macks[$];
    int         rdi = 0;
    int         nstop = 0;

    always @(negedge CLK) begin
        bus = iSDA;
        if (SCL && pscl && psda && !bus) begin
            bc = -1; rd_mode = 1'b0; next_rd = 1'b0; first_byte = 1'b1;
        end else if (SCL && pscl && !psda && bus) begin
            nstop++;
        end else if (SCL && !pscl) begin
            if (bc < 8) sr = {sr[6:0], bus};
            else if (rd_mode) mack_bit = bus;
        end else if (!SCL && pscl) begin
            bc++;
            if (bc == 8) begin
                if (!rd_mode) begin
                    got.push_back(sr);
                    if (first_byte) next_rd = sr[0];
                    slv = (nack_addr && first_byte) ? 1'b1 : 1'b0;
                    first_byte = 1'b0;
                end else begin
                    slv = 1'b1;
                end
            end else if (bc == 9) begin
                bc  = 0;
                slv = 1'b1;
                if (rd_mode) macks.push_back(mack_bit);
                if (rd_mode && mack_bit) rd_mode = 1'b0;
                else if (next_rd) rd_mode = 1'b1;
                if (rd_mode) begin
                    tx = (rdi < rdq.size()) ? rdq[rdi] : 8'hFF;
                    rdi++;
                    slv = tx[7];
                end
            end else if (rd_mode && bc >= 1 && bc <= 7) begin
                slv = tx[7-bc];
            end
        end
        pscl = SCL;
        psda = bus;
    end

    // Timing monitor: SCL run lengths and SDA change offset into the low half.
    int   scnt = 0, lowbad = 0, sdabad = 0, hi_len = 0, ndone = 0;
    logic mscl = 1'b1, mosda = 1'b1;

    always @(negedge CLK) begin
        if (Done === 1'b1) ndone++;
        if (SCL !== mscl) begin
            if (SCL && (scnt + 1 != HP)) lowbad++;
            if (!SCL) hi_len = scnt + 1;
            scnt = 0;
        end else begin
            scnt++;
        end
        if (oSDA !== mosda && !SCL && scnt != HP / 2) sdabad++;
        mscl  = SCL;
        mosda = oSDA;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic rnw, input logic [15:0] ra, input logic [15:0] wd);
        @(negedge CLK);
        Start = 1'b1; RnW = rnw; RegAddr = ra; WrData = wd;
        @(negedge CLK);
        // Scramble the request inputs: the block must use its stored copy.
        Start = 1'b0; RnW = ~rnw; RegAddr = ~ra; WrData = ~wd;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (Done !== 1'b1 && n < max) begin
            @(negedge CLK);
            n++;
        end
        chk("done_seen", {31'd0, Done}, 32'd1);
    endtask

    task automatic chk_write_bytes(input string tag);
        logic [7:0] wexp[5];
        wexp = '{8'h0A, 8'h00, 8'h10, 8'h00, 8'h0B};
        chk({tag, "_nbytes"}, got.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, (i < got.size()) ? got[i] : 8'hxx},
                {24'd0, wexp[i]});
    endtask

    int n, nf, n0;

    initial begin
        Reset = 1'b1; Start = 1'b0; RnW = 1'b0; RegAddr = '0; WrData = '0;
        repeat (2) @(negedge CLK);
        chk("rst_scl",    {31'd0, SCL},    32'd1);
        chk("rst_sda",    {31'd0, oSDA},   32'd1);
        chk("rst_busy",   {31'd0, Busy},   32'd0);
        chk("rst_done",   {31'd0, Done},   32'd0);
        chk("rst_ackerr", {31'd0, AckErr}, 32'd0);
        chk("rst_rddata", {16'd0, RdData}, 32'h0000);
        Reset = 1'b0;

        // Write transaction
        got.delete(); n0 = ndone;
        do_start(1'b0, 16'h0010, 16'h000B);
        chk("wr_busy", {31'd0, Busy}, 32'd1);
        chk("wr_start_sda", {31'd0, oSDA}, 32'd0);
        chk("wr_start_scl", {31'd0, SCL},  32'd1);
        nf = 0;
        while (SCL === 1'b1 && nf < 1000) begin @(negedge CLK); nf++; end
        chk("wr_start_hold", nf, HP);
        wait_done(20000, n);
        chk("wr_len", nf + n, 32'd11625);
        chk("wr_busy_done", {31'd0, Busy}, 32'd1);
        chk("wr_ackerr", {31'd0, AckErr}, 32'd0);
        Start = 1'b1; RnW = 1'b1;         // Start in the Done cycle
        @(negedge CLK);
        Start = 1'b0;
        chk("wr_done_pulse", {31'd0, Done}, 32'd0);
        chk("wr_busy_after", {31'd0, Busy}, 32'd0);
        chk("wr_stop", nstop, 32'd1);
        chk_write_bytes("wr");
        repeat (20) @(negedge CLK);
        chk("done_cycle_start_ignored", {31'd0, Busy}, 32'd0);
        chk("wr_ndone", ndone - n0, 32'd1);

        // Read transaction
        got.delete(); macks.delete(); rdq.delete();
        rdq.push_back(8'hA5); rdq.push_back(8'h3C); rdi = 0;
        do_start(1'b1, 16'h0010, 16'h1234);
        repeat (10000) @(negedge CLK);
        chk("rd_mid_rddata", {16'd0, RdData}, 32'h0000);
        wait_done(20000, n);
        chk("rd_len", 10000 + n, 32'd14250);
        chk("rd_rddata", {16'd0, RdData}, 32'hA53C);
        chk("rd_ackerr", {31'd0, AckErr}, 32'd0);
        @(negedge CLK);
        chk("rd_nbytes", got.size(), 32'd4);
        chk("rd_b0", {24'd0, got[0]}, 32'h0A);
        chk("rd_b2", {24'd0, got[2]}, 32'h10);
        chk("rd_addr_r", {24'd0, got[3]}, 32'h0B);
        chk("rd_nmacks", macks.size(), 32'd2);
        chk("rd_mack", {31'd0, macks[0]}, 32'd0);
        chk("rd_mnack", {31'd0, macks[1]}, 32'd1);
        chk("scl_low_len", lowbad, 32'd0);
        chk("sda_change_pt", sdabad, 32'd0);

        // NACK on the address byte
        got.delete(); nack_addr = 1'b1;
        do_start(1'b0, 16'h1234, 16'h5678);
        wait_done(5000, n);
        chk("nack_len", n, 32'd2625);
        chk("nack_ackerr", {31'd0, AckErr}, 32'd1);
        chk("nack_rddata", {16'd0, RdData}, 32'hA53C);
        @(negedge CLK);
        chk("nack_nbytes", got.size(), 32'd1);
        nack_addr = 1'b0;

        // Reset during REG_LO
        got.delete();
        do_start(1'b0, 16'h0010, 16'h000B);
        repeat (5000) @(negedge CLK);
        n0 = ndone;
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        chk("abort_scl",  {31'd0, SCL},  32'd1);
        chk("abort_sda",  {31'd0, oSDA}, 32'd1);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        repeat (300) @(negedge CLK);
        chk("abort_no_done", ndone - n0, 32'd0);
        chk("abort_idle", {31'd0, Busy}, 32'd0);

        // Second Start during a busy write
        got.delete(); n0 = ndone;
        do_start(1'b0, 16'h0010, 16'h000B);
        repeat (1000) @(negedge CLK);
        Start = 1'b1; RnW = 1'b1; RegAddr = 16'hFFFF; WrData = 16'hFFFF;
        @(negedge CLK);
        Start = 1'b0;
        wait_done(20000, n);
        chk("ign_len", 1001 + n, 32'd11625);
        @(negedge CLK);
        chk_write_bytes("ign");
        repeat (50) @(negedge CLK);
        chk("ign_ndone", ndone - n0, 32'd1);

`ifdef I2C_MASTER_STRETCH_EN
        // Hold SCL low by the target during the WR_HI bit 3 high phase
        got.delete();
        do_start(1'b0, 16'h0010, 16'h000B);
        n = 0;
        while (!(got.size() == 3 && bc == 4 && SCL === 1'b1) && n < 20000) begin
            @(negedge CLK); n++;
        end
        chk("str_reached", {31'd0, n < 20000}, 32'd1);
        repeat (10) @(negedge CLK);
        iSCL = 1'b0;
        repeat (300) @(negedge CLK);
        iSCL = 1'b1;
        n = 0;
        while (SCL === 1'b1 && n < 1000) begin @(negedge CLK); n++; end
        @(negedge CLK);
        chk("str_hi_len", hi_len, HP + 300);
        wait_done(20000, n);
        @(negedge CLK);
        chk_write_bytes("str");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
